dmem_port_arbiter: RTL and testbench

- Shares one single-port data memory between the MR-stage load path and the MW-stage store path of the 8-stage pipeline. This replaces the separate read and write memory instances.
- Stores are posted into a small in-order store buffer. The buffer drains to memory in cycles the load path leaves free.
- Loads forward from pending stores, so every load sees every older store.
- Starvation, buffer-full and flush conditions are resolved by a stall to the pipeline.

---
 rtl/dmem_port_arbiter_pkg.sv | 17 +
 rtl/dmem_port_arbiter_store_buffer_fifo.sv | 86 ++++++++
 rtl/dmem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter and its store buffer.
// The address/data defaults match the Data_Memory instance this port feeds.
package dmem_port_arbiter_pkg;

  localparam int unsigned DmemAddrW = 32;
  localparam int unsigned DmemDataW = 32;

  // Addresses are compared as words: addr[ADDR_W-1:WordLsb].
  localparam int unsigned WordLsb = 2;

  typedef enum logic [1:0] {
    StNormal,
    StDrainPri,
    StFlush
  } arb_state_e;

endpackage

// File: rtl/dmem_port_arbiter_store_buffer_fifo.sv
// In-order store buffer: circular FIFO of {word address, data} with a
// youngest-match associative search port used for load forwarding.
module dmem_port_arbiter_store_buffer_fifo #(
  parameter int unsigned WORD_W = 30,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WORD_W-1:0]      push_word,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   pop,
  output logic [WORD_W-1:0]      head_word,
  output logic [DATA_W-1:0]      head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  input  logic [WORD_W-1:0]      search_word,
  output logic                   search_hit,
  output logic [DATA_W-1:0]      search_data
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WORD_W-1:0] word_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PtrW-1:0]   head_q, tail_q;
  logic [CntW-1:0]   count_q, count_d;

  assign head_word = word_q[head_q];
  assign head_data = data_q[head_q];
  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CntW'(DEPTH));

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Push on a full buffer is only issued together with a pop, so the slot
  // being overwritten is the head that is leaving this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        word_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (push) begin
        word_q[tail_q] <= push_word;
        data_q[tail_q] <= push_data;
        tail_q         <= tail_q + 1'b1;
      end
      if (pop) begin
        head_q <= head_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    logic [PtrW-1:0] idx;
    idx         = '0;
    search_hit  = 1'b0;
    search_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PtrW'(i);
      if ((CntW'(i) < count_q) && (word_q[idx] == search_word)) begin
        search_hit  = 1'b1;
        search_data = data_q[idx];
      end
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates one single-port data memory between the MR load path and the
// MW store path; stores are posted into a store buffer that drains in idle cycles.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = DmemAddrW,
  parameter int unsigned DATA_W       = DmemDataW,
  parameter int unsigned SB_DEPTH     = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ld_req,
  input  logic [ADDR_W-1:0]         ld_addr,
  output logic [DATA_W-1:0]         ld_data,
  output logic                      ld_valid,
  input  logic                      st_req,
  input  logic [ADDR_W-1:0]         st_addr,
  input  logic [DATA_W-1:0]         st_data,
  input  logic                      sb_flush,
  output logic                      stall,
  output logic                      flush_done,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic [$clog2(SB_DEPTH):0] sb_count
);

  localparam int unsigned WordW   = ADDR_W - WordLsb;
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

  arb_state_e state_q, state_d;
  logic [StarveW-1:0] starve_q, starve_d;

  logic [WordW-1:0]  ld_word, st_word, head_word;
  logic [DATA_W-1:0] head_data, sb_hit_data;
  logic              sb_hit, sb_empty, sb_full;
  logic              st_fwd, fwd_hit;
  logic              load_port, drain, push;
  logic [1:0]        unused_st_addr_lsbs;

  assign ld_word             = ld_addr[ADDR_W-1:WordLsb];
  assign st_word             = st_addr[ADDR_W-1:WordLsb];
  assign unused_st_addr_lsbs = st_addr[WordLsb-1:0];

  dmem_port_arbiter_store_buffer_fifo #(
    .WORD_W (WordW),
    .DATA_W (DATA_W),
    .DEPTH  (SB_DEPTH)
  ) u_store_buffer (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_word   (st_word),
    .push_data   (st_data),
    .pop         (drain),
    .head_word   (head_word),
    .head_data   (head_data),
    .count       (sb_count),
    .empty       (sb_empty),
    .full        (sb_full),
    .search_word (ld_word),
    .search_hit  (sb_hit),
    .search_data (sb_hit_data)
  );

  // The MW store is older than the MR load, so it beats any buffered entry.
  assign st_fwd   = st_req && (st_word == ld_word);
  assign fwd_hit  = ld_req && (st_fwd || sb_hit);
  assign ld_data  = !fwd_hit ? mem_rdata : (st_fwd ? st_data : sb_hit_data);
  assign ld_valid = ld_req && !stall;
  assign push     = st_req && !stall;

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    load_port  = 1'b0;
    drain      = 1'b0;
    stall      = 1'b0;
    flush_done = 1'b0;
    unique case (state_q)
      StNormal: begin
        load_port = ld_req && !fwd_hit;
        drain     = !load_port && !sb_empty;
        stall     = st_req && sb_full && !drain;
        if (sb_empty || drain) begin
          starve_d = '0;
        end else begin
          starve_d = starve_q + 1'b1;
        end
        if (sb_flush) begin
          state_d = StFlush;
        end else if (!sb_empty && !drain &&
                     (starve_q == StarveW'(STARVE_LIMIT - 1))) begin
          state_d = StDrainPri;
        end
      end
      StDrainPri: begin
        // Buffer is non-empty here: the counter only advances while entries wait.
        drain    = !sb_empty;
        stall    = (ld_req && !fwd_hit) || (st_req && sb_full && !drain);
        starve_d = '0;
        state_d  = StNormal;
      end
      StFlush: begin
        drain    = !sb_empty;
        stall    = ld_req || st_req;
        starve_d = '0;
        if (sb_empty) begin
          flush_done = 1'b1;
          state_d    = StNormal;
        end
      end
      default: begin
        state_d  = StNormal;
        starve_d = '0;
      end
    endcase
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (drain) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = {head_word, {WordLsb{1'b0}}};
      mem_wdata = head_data;
    end else if (load_port) begin
      mem_en   = 1'b1;
      mem_addr = ld_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StNormal;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed and random stimulus for dmem_port_arbiter, checked each cycle against
// a queue-based model of the store buffer and the memory contents.
module tb_dmem_port_arbiter;

  localparam int unsigned SbDepth     = 4;
  localparam int unsigned StarveLimit = 8;
  localparam int MNormal = 0;
  localparam int MPri    = 1;
  localparam int MFlush  = 2;

  typedef struct {
    logic [29:0] word;
    logic [31:0] data;
  } ent_t;

  logic        clk, reset;
  logic        ld_req, ld_valid, st_req, sb_flush, stall, flush_done;
  logic [31:0] ld_addr, ld_data, st_addr, st_data;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  sb_count;

  logic [31:0] mem [64] = '{default: 32'h0};
  logic [31:0] ref_mem [64];
  ent_t        sb_q [$];
  int          mode, starve;
  int          n_checks, n_fail;

  dmem_port_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .SB_DEPTH     (SbDepth),
    .STARVE_LIMIT (StarveLimit)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ld_req     (ld_req),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .ld_valid   (ld_valid),
    .st_req     (st_req),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .sb_flush   (sb_flush),
    .stall      (stall),
    .flush_done (flush_done),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .sb_count   (sb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr[7:2]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, predict, check at negedge, advance model after posedge.
  task automatic step(input bit lr, input logic [31:0] la, input bit sr,
                      input logic [31:0] sa, input logic [31:0] sd, input bit fl);
    bit hit, rd, dr, stl, done;
    logic [31:0] fd, ea, ew;
    int n;
    ent_t e;
    ld_req = lr; ld_addr = la; st_req = sr; st_addr = sa; st_data = sd; sb_flush = fl;
    n   = sb_q.size();
    hit = 1'b0;
    fd  = ref_mem[la[7:2]];
    if (lr) begin
      if (sr && sa[31:2] == la[31:2]) begin
        hit = 1'b1; fd = sd;
      end else begin
        for (int i = n - 1; i >= 0; i--) begin
          if (sb_q[i].word == la[31:2]) begin
            hit = 1'b1; fd = sb_q[i].data; break;
          end
        end
      end
    end
    rd = 1'b0; done = 1'b0;
    case (mode)
      MNormal: begin
        rd  = lr && !hit;
        dr  = !rd && n > 0;
        stl = sr && n == SbDepth && !dr;
      end
      MPri: begin
        dr  = n > 0;
        stl = (lr && !hit) || (sr && n == SbDepth && !dr);
      end
      default: begin
        dr   = n > 0;
        stl  = lr || sr;
        done = (n == 0);
      end
    endcase
    ea = 32'h0; ew = 32'h0;
    if (dr) begin
      ea = {sb_q[0].word, 2'b00}; ew = sb_q[0].data;
    end else if (rd) begin
      ea = la;
    end
    @(negedge clk);
    chk("stall", stall, stl);
    chk("ld_valid", ld_valid, lr && !stl);
    chk("mem_en", mem_en, dr || rd);
    chk("mem_we", mem_we, dr);
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ew);
    chk("sb_count", sb_count, n);
    chk("flush_done", flush_done, done);
    if (lr && !stl) chk("ld_data", ld_data, fd);
    @(posedge clk);
    #1;
    if (dr) begin
      ref_mem[sb_q[0].word[5:0]] = sb_q[0].data;
      void'(sb_q.pop_front());
    end
    if (sr && !stl) begin
      e.word = sa[31:2]; e.data = sd;
      sb_q.push_back(e);
    end
    case (mode)
      MNormal: begin
        starve = (n == 0 || dr) ? 0 : starve + 1;
        if (fl) mode = MFlush;
        else if (starve >= StarveLimit) mode = MPri;
      end
      MPri: begin
        starve = 0; mode = MNormal;
      end
      default: begin
        starve = 0;
        if (n == 0) mode = MNormal;
      end
    endcase
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset taking effect mid-cycle, checked before any clock edge.
  task automatic do_reset();
    ld_req = 0; ld_addr = 0; st_req = 0; st_addr = 0; st_data = 0; sb_flush = 0;
    reset = 1'b1;
    #2;
    chk("rst_sb_count", sb_count, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_stall", stall, 0);
    chk("rst_flush_done", flush_done, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    sb_q.delete(); mode = MNormal; starve = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1);
  end

  initial begin
    bit          lr, sr, fl;
    logic [31:0] la, sa, sd;
    n_checks = 0; n_fail = 0; mode = MNormal; starve = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    do_reset();

    // Posted store drains on the next free cycle.
    step(0, 0, 1, 32'h40, 32'hA5A5_A5A5, 0);
    idle(2);
    // Same-cycle MW store forwards to the MR load.
    step(1, 32'h80, 1, 32'h80, 32'h11, 0);
    idle(2);
    // Fill with missing loads, fifth store stalls, then starvation breaks it.
    for (int i = 0; i < 4; i++) step(1, 32'h60, 1, 32'h20 + 32'(4 * i), 32'(100 + i), 0);
    for (int i = 0; i < 8; i++) step(1, 32'h60, 1, 32'h30, 32'h55, 0);
    idle(5);
    // One buffered store starved by continuous loads.
    step(0, 0, 1, 32'h44, 32'h77, 0);
    for (int i = 0; i < 11; i++) step(1, 32'h48, 0, 0, 0, 0);
    idle(2);
    // Youngest match wins.
    step(1, 32'h30, 1, 32'h10, 32'h1, 0);
    step(1, 32'h30, 1, 32'h10, 32'h2, 0);
    step(1, 32'h10, 0, 0, 0, 0);
    idle(3);
    step(1, 32'h10, 0, 0, 0, 0);
    // Flush of three entries with requests held.
    for (int i = 0; i < 3; i++) step(1, 32'h70, 1, 32'h50 + 32'(4 * i), $urandom, 0);
    step(1, 32'h70, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 32'h70, 1, 32'h58, 32'h9, 0);
    idle(1);
    // Flush with an empty buffer.
    step(0, 0, 0, 0, 0, 1);
    idle(2);
    // Reset in the middle of a flush.
    for (int i = 0; i < 3; i++) step(1, 32'h70, 1, 32'h20 + 32'(4 * i), $urandom, 0);
    step(1, 32'h70, 0, 0, 0, 1);
    step(0, 0, 1, 32'h0, 32'h3, 0);
    do_reset();
    idle(3);

    for (int k = 0; k < 400; k++) begin
      lr = ($urandom_range(0, 9) < 6);
      sr = ($urandom_range(0, 9) < 5);
      fl = ($urandom_range(0, 99) < 3);
      la = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom)};
      sa = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom)};
      sd = $urandom;
      step(lr, la, sr, sa, sd, fl);
    end
    for (int i = 0; i < 16; i++) step(1, {26'd0, 4'(i), 2'b00}, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
